// File: rtl/control_sequencer_if.sv
// Bundle of every signal between the control sequencer and the ROM,
// the data memory and the register/ALU datapath.
interface control_sequencer_if;
    logic [15:0] instr_in;
    logic [15:0] BusA;
    logic        Z;
    logic        mem_ack;
    logic [5:0]  pc;
    logic [3:0]  DR;
    logic [3:0]  SA;
    logic [3:0]  SB;
    logic [3:0]  FS;
    logic        MB;
    logic        MD;
    logic        RW;
    logic        MP;
    logic        mem_req;
    logic        mem_we;
    logic        halted;

    modport master (
        input  instr_in, BusA, Z, mem_ack,
        output pc, DR, SA, SB, FS, MB, MD, RW, MP, mem_req, mem_we, halted
    );

    modport slave (
        output instr_in, BusA, Z, mem_ack,
        input  pc, DR, SA, SB, FS, MB, MD, RW, MP, mem_req, mem_we, halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control unit: fetches from the program ROM, decodes into the
// datapath control fields and runs loads/stores over a req/ack handshake.
module control_sequencer #(
    parameter logic [3:0] FS_PASSA = 4'h0,
    parameter logic [3:0] FS_PASSB = 4'h7,
    parameter logic [5:0] RESET_PC = 6'd0
) (
    input  logic                clk_main,
    input  logic                reset,
    control_sequencer_if.master bus
);

    typedef enum logic [1:0] {FETCH, EXEC, MEM_WAIT, HALT} state_t;

    state_t      state, stateNext;
    logic [15:0] ir;
    logic [5:0]  pcReg, pcNext;
    logic [3:0]  op;
    logic [3:0]  fs;
    logic        mb, md, rw, mp, memReq, memWe, halted;

    assign op = ir[15:12];

    // Upper bits of BusA never matter: jump targets are 6 bits wide.
    logic unusedBusA;
    assign unusedBusA = ^bus.BusA[15:6];

    // State, PC and instruction register; IR only loads during FETCH so the
    // register fields stay stable through EXEC and the whole memory wait.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            state <= FETCH;
            pcReg <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= stateNext;
            pcReg <= pcNext;
            if (state == FETCH)
                ir <= bus.instr_in;
        end
    end

    // Next state, next PC and the decoded control outputs.
    always_comb begin
        stateNext = state;
        pcNext    = pcReg;
        fs        = 4'h0;
        mb        = 1'b0;
        md        = 1'b0;
        rw        = 1'b0;
        mp        = 1'b0;
        memReq    = 1'b0;
        memWe     = 1'b0;
        halted    = 1'b0;
        case (state)
            FETCH: begin
                pcNext    = pcReg + 6'd1;
                stateNext = EXEC;
            end
            EXEC: begin
                stateNext = FETCH;
                case (op)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        fs = {1'b0, op[2:0]};
                        rw = 1'b1;
                    end
                    4'h8: begin
                        fs = FS_PASSB;
                        mb = 1'b1;
                        rw = 1'b1;
                    end
                    4'h9, 4'hA: begin
                        // mem_ack is deliberately ignored here; a stale ack
                        // must not complete a request that was just issued.
                        memReq    = 1'b1;
                        memWe     = (op == 4'hA);
                        stateNext = MEM_WAIT;
                    end
                    4'hB: begin
                        fs = FS_PASSA;
                        if (bus.Z)
                            pcNext = pcReg + {{2{ir[11]}}, ir[11:8]};
                    end
                    4'hC: begin
                        mp     = 1'b1;
                        rw     = 1'b1;
                        pcNext = {ir[5:4], ir[3:0]};
                    end
                    4'hD: pcNext = bus.BusA[5:0];
                    4'hE: ;
                    default: stateNext = HALT;
                endcase
            end
            MEM_WAIT: begin
                memReq = 1'b1;
                memWe  = (op == 4'hA);
                if (bus.mem_ack) begin
                    stateNext = FETCH;
                    if (op == 4'h9) begin
                        md = 1'b1;
                        rw = 1'b1;
                    end
                end
            end
            default: halted = 1'b1;
        endcase
        // While reset is held every enable and request is forced quiet,
        // whatever state the machine is leaving.
        if (reset) begin
            fs     = 4'h0;
            mb     = 1'b0;
            md     = 1'b0;
            rw     = 1'b0;
            mp     = 1'b0;
            memReq = 1'b0;
            memWe  = 1'b0;
            halted = 1'b0;
        end
    end

    assign bus.pc      = pcReg;
    assign bus.DR      = ir[11:8];
    assign bus.SA      = ir[7:4];
    assign bus.SB      = ir[3:0];
    assign bus.FS      = fs;
    assign bus.MB      = mb;
    assign bus.MD      = md;
    assign bus.RW      = rw;
    assign bus.MP      = mp;
    assign bus.mem_req = memReq;
    assign bus.mem_we  = memWe;
    assign bus.halted  = halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus random programs, each
// instruction checked cycle by cycle against an instruction-level model.
module tb_control_sequencer;

    localparam logic [3:0] PASSA = 4'h0;
    localparam logic [3:0] PASSB = 4'h7;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] rom [64];

    int ncmp  = 0;
    int nfail = 0;

    // Model state: architectural PC and last fetched instruction.
    logic [5:0]  mpc;
    logic [15:0] mir;

    control_sequencer_if bus ();

    control_sequencer #(.FS_PASSA(PASSA), .FS_PASSB(PASSB), .RESET_PC(6'd0)) dut (
        .clk_main (clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    assign bus.instr_in = rom[bus.pc];

    logic [28:0] obs;
    assign obs = {bus.pc, bus.DR, bus.SA, bus.SB, bus.FS, bus.MB, bus.MD,
                  bus.RW, bus.MP, bus.mem_req, bus.mem_we, bus.halted};

    // Control fields the spec requires during EXEC for a given instruction.
    function automatic logic [10:0] exec_ctrl(input logic [15:0] w);
        logic [3:0] o;
        logic [3:0] f;
        logic mbE, rwE, mpE, rqE, weE;
        o = w[15:12];
        f = 4'h0; mbE = 0; rwE = 0; mpE = 0; rqE = 0; weE = 0;
        if (o < 4'h8) begin f = {1'b0, o[2:0]}; rwE = 1; end
        else if (o == 4'h8) begin f = PASSB; mbE = 1; rwE = 1; end
        else if (o == 4'h9 || o == 4'hA) begin rqE = 1; weE = (o == 4'hA); end
        else if (o == 4'hB) f = PASSA;
        else if (o == 4'hC) begin mpE = 1; rwE = 1; end
        return {f, mbE, 1'b0, rwE, mpE, rqE, weE, 1'b0};
    endfunction

    // Run one instruction placed at the model PC and check every cycle.
    task automatic step_instr(input logic [15:0] w, input logic z, input logic [15:0] ba,
                              input int dly, input logic ackEx);
        logic [28:0] exp;
        logic [3:0]  o;
        int          off;
        rom[mpc] = w;
        o = w[15:12];
        @(negedge clk);
        bus.mem_ack = 1'($urandom_range(0, 1));
        bus.Z = 1'($urandom_range(0, 1));
        #1;
        exp = {mpc, mir[11:0], 4'h0, 7'b0};
        ncmp++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL fetch pc=%0d: got %h want %h", mpc, obs, exp);
        end
        @(posedge clk);
        mir = w;
        mpc = mpc + 6'd1;
        @(negedge clk);
        bus.Z = z; bus.BusA = ba; bus.mem_ack = ackEx;
        #1;
        exp = {mpc, mir[11:0], exec_ctrl(w)};
        ncmp++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL exec w=%h: got %h want %h", w, obs, exp);
        end
        @(posedge clk);
        if (o == 4'hB && z) begin
            off = (w[11] ? int'(w[11:8]) - 16 : int'(w[11:8]));
            mpc = 6'((int'(mpc) + off + 64) % 64);
        end else if (o == 4'hC) mpc = {w[5:4], w[3:0]};
        else if (o == 4'hD) mpc = ba[5:0];
        if (o == 4'h9 || o == 4'hA) begin
            for (int k = 0; k <= dly; k++) begin
                @(negedge clk);
                bus.mem_ack = (k == dly);
                bus.BusA = 16'($urandom);
                #1;
                exp = {mpc, mir[11:0], 4'h0, 1'b0, (k == dly) && o == 4'h9,
                       (k == dly) && o == 4'h9, 1'b0, 1'b1, o == 4'hA, 1'b0};
                ncmp++;
                if (obs !== exp) begin
                    nfail++;
                    $display("FAIL memwait w=%h k=%0d: got %h want %h", w, k, obs, exp);
                end
                @(posedge clk);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.mem_ack = 1'b1; bus.Z = 1'b1; bus.BusA = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        ncmp++;
        if (obs !== 29'h0) begin
            nfail++;
            $display("FAIL reset_outputs: got %h want %h", obs, 29'h0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        mpc = 6'd0; mir = 16'h0;
    endtask

    task automatic test_alu_ldi();
        step_instr(16'h8125, 0, 16'h0, 0, 0);
        step_instr(16'h8203, 1, 16'h0, 0, 0);
        step_instr(16'h2312, 0, 16'h0, 0, 0);
        #1;
        ncmp++;
        if (bus.pc !== 6'd3) begin
            nfail++;
            $display("FAIL alu_pc: got %0d want 3", bus.pc);
        end
    endtask

    task automatic test_load_store();
        step_instr(16'h9410, 0, 16'h0, 2, 0);
        #1;
        ncmp++;
        if (bus.pc !== 6'd4) begin
            nfail++;
            $display("FAIL ld_pc: got %0d want 4", bus.pc);
        end
        step_instr(16'hA520, 0, 16'h0, 0, 1);
    endtask

    task automatic test_jal_jr();
        step_instr(16'hC523, 0, 16'h0, 0, 0);
        #1;
        ncmp++;
        if (bus.pc !== 6'h23) begin
            nfail++;
            $display("FAIL jal_pc: got %0d want 35", bus.pc);
        end
        step_instr(16'hD050, 0, 16'd6, 0, 0);
        #1;
        ncmp++;
        if (bus.pc !== 6'd6) begin
            nfail++;
            $display("FAIL jr_pc: got %0d want 6", bus.pc);
        end
    endtask

    task automatic test_branch();
        step_instr(16'hD000, 0, 16'd10, 0, 0);
        step_instr(16'hBE10, 1, 16'h0, 0, 0);
        #1;
        ncmp++;
        if (bus.pc !== 6'd9) begin
            nfail++;
            $display("FAIL brz_taken: got %0d want 9", bus.pc);
        end
        step_instr(16'hD000, 0, 16'd10, 0, 0);
        step_instr(16'hBE10, 0, 16'h0, 0, 0);
        #1;
        ncmp++;
        if (bus.pc !== 6'd11) begin
            nfail++;
            $display("FAIL brz_not_taken: got %0d want 11", bus.pc);
        end
        step_instr(16'hD000, 0, 16'd62, 0, 0);
        step_instr(16'hB710, 1, 16'h0, 0, 0);
        #1;
        ncmp++;
        if (bus.pc !== 6'd6) begin
            nfail++;
            $display("FAIL brz_wrap: got %0d want 6", bus.pc);
        end
    endtask

    task automatic test_halt();
        logic [28:0] exp;
        step_instr(16'hF000, 0, 16'h0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.mem_ack = 1'($urandom_range(0, 1));
            bus.Z = 1'($urandom_range(0, 1));
            #1;
            exp = {mpc, mir[11:0], 4'h0, 6'b0, 1'b1};
            ncmp++;
            if (obs !== exp) begin
                nfail++;
                $display("FAIL halt k=%0d: got %h want %h", k, obs, exp);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset_mid_mem();
        test_reset();
        rom[0] = 16'h9410;
        bus.mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ncmp++;
        if (bus.mem_req !== 1'b1) begin
            nfail++;
            $display("FAIL mid_mem_req_before: got %b want 1", bus.mem_req);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        ncmp++;
        if ({bus.mem_req, bus.pc} !== 7'h0) begin
            nfail++;
            $display("FAIL mid_mem_reset: got req=%b pc=%0d want req=0 pc=0", bus.mem_req, bus.pc);
        end
        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        mpc = 6'd0; mir = 16'h0;
        step_instr(16'h8125, 0, 16'h0, 0, 0);
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int n = 0; n < 300; n++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'hE;
            step_instr(w, 1'($urandom_range(0, 1)), 16'($urandom),
                       int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 16'hE000;
        bus.BusA = 16'h0; bus.Z = 1'b0; bus.mem_ack = 1'b0; reset = 1'b1;
        test_reset();
        test_alu_ldi();
        test_load_store();
        test_jal_jr();
        test_branch();
        test_halt();
        test_reset_mid_mem();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control unit that sequences the 16-bit register/ALU datapath.
- Fetches instructions from program memory at PC and decodes them into the datapath control fields (DR, SA, SB, FS, MB, MD, RW, MP) and the current PC.
- Runs loads and stores to data memory through a req/ack handshake.
- Sits between program ROM, data memory and the datapath. It is the only source of the datapath's PC and control inputs.

Parameters:
- FS_PASSA, 4'h0, FS code for which the ALU passes A (used by BRZ for the Z test)
- FS_PASSB, 4'h7, FS code for which the ALU passes B (used by LDI)
- RESET_PC, 6'd0, PC value loaded on reset

Ports:
- clk_main  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- instr_in  in  16  program memory word at address pc (combinational ROM)
- BusA  in  16  datapath register A output (JR target)
- Z  in  1  datapath ALU zero flag
- mem_ack  in  1  data memory completion strobe
- pc  out  6  program counter; also drives the datapath PC input
- DR, SA, SB  out  4 each  register addresses, equal to IR[11:8], IR[7:4], IR[3:0] in every state
- FS  out  4  ALU function select
- MB, MD, RW, MP  out  1 each  datapath mux selects and register write enable
- mem_req  out  1  data memory request
- mem_we  out  1  1 = store, 0 = load; valid while mem_req=1
- halted  out  1  high while in HALT

Behaviour:
Instruction format: op = IR[15:12], dr = IR[11:8], sa = IR[7:4], sb = IR[3:0].

States: FETCH, EXEC, MEM_WAIT, HALT.

Reset (any state, including mid-transaction):
- state=FETCH, pc=RESET_PC, IR=0.
- RW, MB, MD, MP, mem_req, mem_we, halted, FS all 0.
- An outstanding mem_req is dropped; a late mem_ack is ignored.

FETCH (1 cycle):
- IR <= instr_in, pc <= pc+1 (mod 64, 63 wraps to 0).
- Go to EXEC. RW=0, mem_req=0.

EXEC (1 cycle). In this state pc already holds the return address. Per op:
- 0x0-0x7 ALU: FS={1'b0,op[2:0]}, MB=0, MD=0, MP=0, RW=1. Go to FETCH.
- 0x8 LDI: FS=FS_PASSB, MB=1 (B = {8'b0,sa,sb}), RW=1. Go to FETCH.
- 0x9 LD / 0xA ST: mem_req=1, mem_we=(op==0xA), RW=0. Go to MEM_WAIT. mem_ack is not sampled in EXEC.
- 0xB BRZ: FS=FS_PASSA. If Z=1, pc <= pc + sign_extend(dr), 4-bit offset range -8..+7, mod 64. Else pc unchanged. RW=0. Go to FETCH.
- 0xC JAL: MP=1, RW=1 (writes pc into R[dr]); pc <= {sa[1:0],sb}. Go to FETCH.
- 0xD JR: pc <= BusA[5:0]. RW=0. Go to FETCH.
- 0xE NOP: go to FETCH.
- 0xF HALT: go to HALT.

MEM_WAIT:
- mem_req=1 and mem_we are held stable, and the IR fields are held stable, until mem_ack=1.
- In the mem_ack cycle for LD: MD=1, RW=1 (R[dr] <= data). For ST: RW=0.
- Go to FETCH after the ack. No timeout; waiting is unbounded.

HALT:
- halted=1, all enables 0, pc frozen. Only reset exits.

General rules:
- RW is 1 for exactly one cycle per writing instruction and 0 in FETCH and HALT.
- MB, MD and MP are 0 except in the cases listed above.

Latency (cycles):
- ALU, LDI, branch, jump: 2.
- LD/ST: 2 + number of MEM_WAIT cycles (at least 3).

Test Plan:
- Reset, then ROM[0]=0x8125 (LDI R1), ROM[1]=0x8203, ROM[2]=0x2312 -> cycle 2 after reset: RW=1, MB=1, FS=FS_PASSB, DR=1. pc reads 1,2,3 at the EXEC cycles. ALU op: FS=4'h2, DR=3, SA=1, SB=2.
- LD at ROM[3]=0x9410, mem_ack delayed 3 cycles -> mem_req=1, mem_we=0 for 4 consecutive cycles. RW=MD=1 only in the ack cycle. Next FETCH reads pc=4.
- ST with mem_ack held high from the EXEC cycle -> ack ignored in EXEC. Store completes in the first MEM_WAIT cycle; RW stays 0 throughout.
- BRZ 0xBE10 at pc=10 with Z=1 -> pc=9 (11-2). Same instruction with Z=0 -> pc=11. BRZ 0xB710 at pc=62 -> pc wraps to 6.
- JAL 0xC523 at pc=5 -> RW=1, MP=1, DR=5 while pc=6; pc becomes 0x23. Follow with JR on R5 (BusA=6) -> pc=6.
- HALT 0xF000 -> halted=1, pc frozen for 20 cycles. Reset asserted during MEM_WAIT -> mem_req=0 next cycle, pc=0, state FETCH.
